// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryption core: forward key expansion to K32, whitening,
// then 31 inverse rounds (one per cycle) while the key schedule is unwound.
module present_decrypt #(
  parameter int size       = 64,
  parameter int key_size   = 80,
  parameter int num_rounds = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [key_size-1:0] orig_key,
  input  logic [size-1:0]     ciphertext,
  output logic [size-1:0]     plaintext,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] KEYEXP = 2'd1;
  localparam logic [1:0] WHITEN = 2'd2;
  localparam logic [1:0] ROUND  = 2'd3;

  localparam logic [4:0] LAST_CNT = 5'(num_rounds - 1);

  logic [1:0]          fsm;
  logic [key_size-1:0] key_reg;
  logic [size-1:0]     state_reg;
  logic [4:0]          cnt;
  logic [size-1:0]     round_out;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'hE;
      4'h2: y = 4'hF;
      4'h3: y = 4'h8;
      4'h4: y = 4'hC;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hD;
      4'h8: y = 4'hB;
      4'h9: y = 4'h4;
      4'hA: y = 4'h6;
      4'hB: y = 4'h3;
      4'hC: y = 4'h0;
      4'hD: y = 4'h7;
      4'hE: y = 4'h9;
      default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned n = 0; n < 16; n++) begin
      y[n*4 +: 4] = sbox_inv(x[n*4 +: 4]);
    end
    return y;
  endfunction

  // Output bit j takes input bit P(j) = 16*j mod 63; bit 63 is fixed.
  function automatic logic [63:0] inv_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned j = 0; j < 63; j++) begin
      y[j] = x[(16 * j) % 63];
    end
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ rc;
    r[79:76]   = sbox_inv(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

  always_comb begin
    round_out = inv_sbox_layer(inv_perm(state_reg)) ^ key_reg[79:16];
  end

  assign busy = (fsm != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= IDLE;
      key_reg   <= '0;
      state_reg <= '0;
      cnt       <= '0;
      plaintext <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            key_reg   <= orig_key;
            state_reg <= ciphertext;
            cnt       <= 5'd1;
            fsm       <= KEYEXP;
          end
        end
        KEYEXP: begin
          key_reg <= key_fwd(key_reg, cnt);
          cnt     <= cnt + 5'd1;
          if (cnt == LAST_CNT) fsm <= WHITEN;
        end
        WHITEN: begin
          state_reg <= state_reg ^ key_reg[79:16];
          key_reg   <= key_inv(key_reg, LAST_CNT);
          cnt       <= LAST_CNT;
          fsm       <= ROUND;
        end
        ROUND: begin
          state_reg <= round_out;
          if (cnt != 5'd1) begin
            key_reg <= key_inv(key_reg, cnt - 5'd1);
            cnt     <= cnt - 5'd1;
          end else begin
            plaintext <= round_out;
            done      <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/present_decrypt.md
# present_decrypt

Iterative PRESENT-80 decryption core: it recovers the 64-bit plaintext from a 64-bit ciphertext and 80-bit original key. It is the inverse counterpart of the `Test_Encrypt` core, with matching port names and widths, so the two sit back to back in loopback benches and in the datapath. On each start, the block first runs the forward key schedule to derive the final round key K32. It then runs 31 inverse rounds, one per cycle, while unwinding the key schedule.

## Interface
- `size`, 64: block width in bits (fixed).
- `key_size`, 80: key width in bits; only 80 is supported.
- `num_rounds`, 32: round-key count K1..K32; 31 full rounds plus final whitening.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request pulse; sampled only in IDLE.
- `orig_key`  in  80  user key K; sampled on the accepting edge.
- `ciphertext`  in  64  input block; sampled on the accepting edge.
- `plaintext`  out  64  result register; holds its value until the next completion.
- `busy`  out  1  high while a decryption is in flight.
- `done`  out  1  one-cycle completion pulse.

## Operation
- **FSM states:** IDLE, KEYEXP, WHITEN, ROUND.
- **Registers:** `key_reg[79:0]`, `state_reg[63:0]`, `cnt[4:0]`. Round key = `key_reg[79:16]`.
- **IDLE, start=1:** `key_reg`<=`orig_key`; `state_reg`<=`ciphertext`; `cnt`<=1; go to KEYEXP.
- **KEYEXP (forward schedule):**
  - Rotate: key = {key[18:0], key[79:19]}.
  - Then key[79:76] = S(key[79:76]) and key[19:15] ^= cnt.
  - `cnt`++. After the update with cnt=31, go to WHITEN; `key_reg` now holds K32.
- **WHITEN:**
  - `state_reg` ^= K32.
  - `key_reg`<=invupd(`key_reg`, 31), giving K31.
  - `cnt`<=31; go to ROUND.
- **invupd(k, i):**
  - key[19:15] ^= i.
  - Then key[79:76] = S⁻¹(key[79:76]).
  - Then rotate right 61: key = {key[60:0], key[79:61]}.
- **ROUND (cnt = 31 down to 1):**
  - `state_reg` <= S⁻¹layer(P⁻¹(`state_reg`)) ^ `key_reg`[79:16].
  - If cnt>1: `key_reg`<=invupd(`key_reg`, cnt-1); `cnt`--.
  - If cnt==1: `plaintext`<=result; `done`<=1; go to IDLE.
- **Inverse permutation:** P⁻¹ maps bit j of the output to bit P(j) of the input, where P(i) = 16·i mod 63 for i<63 and P(63) = 63.
- **S-boxes:** S = C56B90AD3EF84712 (hex, index 0..F). S⁻¹ = 5EF8C12DB463079A. Applied nibble-wise to all 16 nibbles.
- **start outside IDLE** is ignored; there is no queueing.
- **Inputs** are not required to be stable after the accepting edge.

## Timing
- **Reset values:** `plaintext`=0, `busy`=0, `done`=0, FSM=IDLE, `cnt`=0, `key_reg`=0, `state_reg`=0.
- **Reset mid-operation** aborts immediately. No `done` is produced and `plaintext` returns to 0.
- **Accepting edge E0:** `busy` is 1 from E0 until E63, inclusive of the cycle before E63.
- **Edge breakdown:**
  - KEYEXP occupies edges E1..E31.
  - WHITEN is E32.
  - ROUND occupies E33..E63.
- **Completion at E63:** `plaintext` is valid, `done`=1 and `busy`=0.
- **After completion:** `done` drops at E64 unless a new completion coincides, which is impossible with this latency.
- **Total latency:** 63 cycles from accept to `done`.
- **Back-to-back:** start=1 during the `done` cycle is accepted at E64.
- `done` and `busy` are never both 1.

## Test plan
- **Known answer 1:** key=0, ciphertext=5579C1387B228445, start pulse -> `done` 63 cycles after the accept edge; `plaintext`=0000000000000000.
- **Known answer 2:**
  - key=FFFFFFFFFFFFFFFFFFFF, ciphertext=E72C46C0F5945049 -> `plaintext`=0000000000000000.
  - key=0, ciphertext=A112FFC72F68417B -> `plaintext`=FFFFFFFFFFFFFFFF.
  - key=all-F, ciphertext=3333DCD3213210D2 -> `plaintext`=FFFFFFFFFFFFFFFF.
- **Start while busy:** pulse `start` at cycle 10 with different `ciphertext`/`orig_key` -> ignored. The first result is unchanged, `done` pulses exactly once and `busy` stays high without gaps.
- **Reset mid-operation:** drop `rst` asynchronously at cycle 40, mid-ROUND -> outputs 0 immediately and no `done`. A new start after release of `rst` yields the correct result for known answer 1.
- **Back-to-back and loopback:** assert start in the `done` cycle -> second result 63 cycles later. Then drive 20 random key/plaintext pairs through `Test_Encrypt` followed by this block -> original plaintext recovered with zero errors, and `plaintext` held stable between `done` pulses.
